// File: rtl/sms32_19_inv_seq.sv
// Sequential inverse of the power-19 S-box over GF(2^6) (x^6+x+1): y = x^10.
// One tower-field GF((2^3)^2) multiplier is shared across a square-and-multiply schedule.
module sms32_19_inv_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] x,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] y,
    output logic       busy
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SQ1  = 3'd1;
    localparam logic [2:0] SQ2  = 3'd2;
    localparam logic [2:0] SQ3  = 3'd3;
    localparam logic [2:0] MUL  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    function automatic logic [5:0] std_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r;
        logic [5:0] s;
        r = '0;
        s = a;
        for (int unsigned i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ s;
            s = {s[4:0], 1'b0} ^ (s[5] ? 6'h03 : 6'h00);
        end
        return r;
    endfunction

    function automatic logic [5:0] lin_map(input logic [35:0] cols, input logic [5:0] v);
        logic [5:0] r;
        r = '0;
        for (int unsigned i = 0; i < 6; i++)
            if (v[i]) r = r ^ cols[6*i +: 6];
        return r;
    endfunction

    // Tower -> standard basis images are found at elaboration: beta is a root of
    // t^3+t^2+1 (normal basis beta, beta^2, beta^4), z a root of z^2+z+1.
    function automatic logic [35:0] inv_iso_cols();
        logic [5:0] b8;
        logic [5:0] zr;
        logic [5:0] v;
        logic [5:0] b2;
        logic [5:0] b4;
        logic       fb;
        logic       fz;
        b8 = '0;
        zr = '0;
        fb = 1'b0;
        fz = 1'b0;
        for (int unsigned t = 1; t < 64; t++) begin
            v = 6'(t);
            if (!fb && (std_mul(std_mul(v, v), v) ^ std_mul(v, v) ^ 6'h01) == 6'h00) begin
                b8 = v;
                fb = 1'b1;
            end
            if (!fz && (std_mul(v, v) ^ v ^ 6'h01) == 6'h00) begin
                zr = v;
                fz = 1'b1;
            end
        end
        b2 = std_mul(b8, b8);
        b4 = std_mul(b2, b2);
        return {std_mul(b4, zr), std_mul(b2, zr), std_mul(b8, zr), b4, b2, b8};
    endfunction

    function automatic logic [35:0] iso_cols(input logic [35:0] inv_cols);
        logic [35:0] c;
        c = '0;
        for (int unsigned j = 0; j < 6; j++)
            for (int unsigned t = 0; t < 64; t++)
                if (lin_map(inv_cols, 6'(t)) == 6'(1 << j)) c[6*j +: 6] = 6'(t);
        return c;
    endfunction

    // GF(2^3) in normal basis {b, b^2, b^4}, bit i = coefficient of b^(2^i)
    function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
        logic p01;
        logic p02;
        logic p12;
        p01 = (a[0] & b[1]) ^ (a[1] & b[0]);
        p02 = (a[0] & b[2]) ^ (a[2] & b[0]);
        p12 = (a[1] & b[2]) ^ (a[2] & b[1]);
        return {(a[1] & b[1]) ^ p01 ^ p02,
                (a[0] & b[0]) ^ p02 ^ p12,
                (a[2] & b[2]) ^ p01 ^ p12};
    endfunction

    function automatic logic [5:0] tower_mul(input logic [5:0] a, input logic [5:0] b);
        logic [2:0] hh;
        logic [2:0] ll;
        logic [2:0] mm;
        hh = gf8_mul(a[5:3], b[5:3]);
        ll = gf8_mul(a[2:0], b[2:0]);
        mm = gf8_mul(a[5:3] ^ a[2:0], b[5:3] ^ b[2:0]);
        return {mm ^ ll, hh ^ ll};
    endfunction

    localparam logic [35:0] INV_ISO_COLS = inv_iso_cols();
    localparam logic [35:0] ISO_COLS     = iso_cols(INV_ISO_COLS);

    logic [2:0] state;
    logic [5:0] acc;
    logic [5:0] sq2;
    logic [5:0] y_q;
    logic [5:0] iso_x;
    logic [5:0] op_b;
    logic [5:0] prod;
    logic [5:0] y_next;

    always_comb begin
        iso_x  = lin_map(ISO_COLS, x);
        op_b   = (state == MUL) ? sq2 : acc;
        prod   = tower_mul(acc, op_b);
        y_next = lin_map(INV_ISO_COLS, prod);
    end

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign y         = y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            sq2   <= '0;
            y_q   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    acc   <= iso_x;
                    state <= SQ1;
                end
                SQ1: begin
                    acc   <= prod;
                    sq2   <= prod;
                    state <= SQ2;
                end
                SQ2: begin
                    acc   <= prod;
                    state <= SQ3;
                end
                SQ3: begin
                    acc   <= prod;
                    state <= MUL;
                end
                MUL: begin
                    y_q   <= y_next;
                    state <= DONE;
                end
                DONE: if (out_ready) begin
                    if (in_valid) begin
                        acc   <= iso_x;
                        state <= SQ1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sms32_19_inv_seq.sv
// Self-checking bench for sms32_19_inv_seq against a plain GF(2^6) power model.
module tb_sms32_19_inv_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] x;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] y;
    logic       busy;

    int total = 0;
    int bad   = 0;

    sms32_19_inv_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] gmul(input logic [5:0] a, input logic [5:0] b);
        logic [10:0] p;
        p = '0;
        for (int i = 0; i < 6; i++)
            if (b[i]) p = p ^ ({5'b0, a} << i);
        for (int k = 10; k >= 6; k--)
            if (p[k]) p = p ^ (11'h43 << (k - 6));
        return p[5:0];
    endfunction

    function automatic logic [5:0] gpow(input logic [5:0] a, input int e);
        logic [5:0] r;
        r = 6'h01;
        for (int i = 0; i < e; i++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [5:0] fwd(input logic [5:0] a);
        return gpow(a, 19);
    endfunction

    function automatic logic [5:0] ref_inv(input logic [5:0] a);
        return gpow(a, 10);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Accept one input from IDLE, wait (bounded) for the result, then consume it.
    task automatic run_one(input logic [5:0] xin, output logic [5:0] yout, output int lat);
        in_valid = 1'b1;
        x = xin;
        step();
        in_valid = 1'b0;
        x = 6'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        if (!out_valid) lat = -1;
        yout = y;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; in_valid = 1'b1; x = 6'h3F; out_ready = 1'b0;
        step();
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 6'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b y=%h busy=%b, want 1 0 00 0",
                     in_ready, out_valid, y, busy);
        end
        rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        total++;
        if (n !== 4 || y !== ref_inv(6'h3F)) begin
            bad++;
            $display("FAIL reset_first_op: latency=%0d y=%h, want 4 %h", n, y, ref_inv(6'h3F));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_zero_one();
        logic [5:0] r;
        int lat;
        run_one(6'h00, r, lat);
        total++;
        if (r !== 6'h00 || lat !== 4) begin
            bad++;
            $display("FAIL zero: y=%h lat=%0d, want 00 4", r, lat);
        end
        run_one(fwd(6'h01), r, lat);
        total++;
        if (r !== 6'h01 || lat !== 4) begin
            bad++;
            $display("FAIL one: y=%h lat=%0d, want 01 4", r, lat);
        end
    endtask

    task automatic test_roundtrip();
        logic [5:0] r;
        int lat;
        bit seen [64];
        for (int i = 0; i < 64; i++) begin
            run_one(fwd(6'(i)), r, lat);
            total++;
            if (r !== 6'(i) || lat !== 4) begin
                bad++;
                $display("FAIL roundtrip[%0d]: y=%h lat=%0d, want %h 4", i, r, lat, 6'(i));
            end
        end
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            run_one(6'(i), r, lat);
            total++;
            if (seen[r] || r !== ref_inv(6'(i))) begin
                bad++;
                $display("FAIL distinct[%0d]: y=%h dup=%b, want %h unique", i, r, seen[r], ref_inv(6'(i)));
            end
            seen[r] = 1'b1;
        end
    endtask

    task automatic test_random();
        logic [5:0] xi;
        logic [5:0] y0;
        int n;
        int d;
        for (int k = 0; k < 16; k++) begin
            xi = 6'($urandom);
            d = int'($urandom_range(0, 3));
            in_valid = 1'b1; x = xi;
            step();
            in_valid = 1'b0; x = 6'($urandom);
            n = 0;
            while (!out_valid && n < 20) begin
                step();
                n++;
            end
            y0 = y;
            for (int w = 0; w < d; w++) step();
            total++;
            if (n !== 4 || out_valid !== 1'b1 || y !== y0 || y0 !== ref_inv(xi)) begin
                bad++;
                $display("FAIL random[%0d]: x=%h y=%h lat=%0d ov=%b, want %h 4 1",
                         k, xi, y, n, out_valid, ref_inv(xi));
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int n;
        in_valid = 1'b1; x = fwd(6'h2A);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        for (int c = 0; c < 7; c++) begin
            total++;
            if (out_valid !== 1'b1 || y !== 6'h2A || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure[%0d]: ov=%b y=%h in_ready=%b, want 1 2a 0",
                         c, out_valid, y, in_ready);
            end
            in_valid = c[0];
            x = 6'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || y !== 6'h2A) begin
            bad++;
            $display("FAIL backpressure_release: ov=%b busy=%b in_ready=%b y=%h, want 0 0 1 2a",
                     out_valid, busy, in_ready, y);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] items [3];
        logic [5:0] got [$];
        int when [$];
        int idx;
        items[0] = 6'h05; items[1] = 6'h09; items[2] = 6'h30;
        idx = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (out_valid) begin
                got.push_back(y);
                when.push_back(c);
            end
            if (in_ready && idx < 3) begin
                in_valid = 1'b1;
                x = fwd(items[idx]);
                idx++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        total++;
        if (got.size() !== 3) begin
            bad++;
            $display("FAIL b2b_count: results=%0d, want 3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got[i] !== items[i]) begin
                    bad++;
                    $display("FAIL b2b_data[%0d]: y=%h, want %h", i, got[i], items[i]);
                end
            end
            total++;
            if (when[1] - when[0] !== 5 || when[2] - when[1] !== 5) begin
                bad++;
                $display("FAIL b2b_spacing: gaps=%0d,%0d, want 5,5", when[1] - when[0], when[2] - when[1]);
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [5:0] r;
        int lat;
        int rises;
        in_valid = 1'b1; x = 6'h17;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++;
        if (out_valid !== 1'b0 || y !== 6'h00 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midop_reset: ov=%b y=%h busy=%b, want 0 00 0", out_valid, y, busy);
        end
        rises = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) rises++;
            step();
        end
        total++;
        if (rises !== 0 || y !== 6'h00) begin
            bad++;
            $display("FAIL midop_abandoned: valid_cycles=%0d y=%h, want 0 00", rises, y);
        end
        run_one(fwd(6'h3C), r, lat);
        total++;
        if (r !== 6'h3C || lat !== 4) begin
            bad++;
            $display("FAIL midop_next: y=%h lat=%0d, want 3c 4", r, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; x = '0; out_ready = 1'b0;
        step();
        test_reset();
        test_zero_one();
        test_roundtrip();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
